// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - UART 8N1 receiver with first-word-fall-through FIFO; optional 8E1 via SERIAL_RECEIVER_PARITY_EN
module serial_receiver #(
    parameter int CLK_IN = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     framing_error,
    output logic                     overrun,
    output logic                     parity_error
);

    localparam int BIT_CYCLES  = CLK_IN / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES + 1);
    localparam int AW          = $clog2(DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_RECEIVER_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t        state, state_next;
    logic          sync1, line;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shift, shift_next;
    logic          wr_req, wr_req_next;
    logic          ferr_next;
    logic          perr_next;
    logic          bit_end;

`ifdef SERIAL_RECEIVER_PARITY_EN
    logic          par_bit, par_next;
    logic          perr_q;
`endif

    assign bit_end = (cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            line          <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            wr_req        <= 1'b0;
            framing_error <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
            par_bit       <= 1'b0;
            perr_q        <= 1'b0;
`endif
        end else begin
            sync1         <= rx;
            line          <= sync1;
            state         <= state_next;
            cnt           <= cnt_next;
            idx           <= idx_next;
            shift         <= shift_next;
            wr_req        <= wr_req_next;
            framing_error <= ferr_next;
`ifdef SERIAL_RECEIVER_PARITY_EN
            par_bit       <= par_next;
            perr_q        <= perr_next;
`endif
        end
    end

`ifdef SERIAL_RECEIVER_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        idx_next    = idx;
        shift_next  = shift;
        wr_req_next = 1'b0;
        ferr_next   = 1'b0;
        perr_next   = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        par_next    = par_bit;
`endif
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (!line) state_next = S_START;
            end
            S_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = line ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = {line, shift[7:1]};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
`ifdef SERIAL_RECEIVER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    par_next   = line;
                    state_next = S_STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (!line) begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
`ifdef SERIAL_RECEIVER_PARITY_EN
                    end else if (^{shift, par_bit}) begin
                        perr_next  = 1'b1;
                        state_next = S_IDLE;
`endif
                    end else begin
                        wr_req_next = 1'b1;
                        state_next  = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (line) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          pop, push;

    assign valid      = (count != '0);
    assign empty      = !valid;
    assign full       = (count == (AW+1)'(DEPTH));
    assign data_count = count;
    assign dout       = mem[rd_ptr];
    assign pop        = rd_en && valid;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
    assign push       = wr_req && (!full || pop);
    assign overrun    = wr_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed scoreboard bench for serial_receiver
module tb_serial_receiver;

    localparam int BITC  = 100;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       valid, empty, full;
    logic [2:0] data_count;
    logic       framing_error, overrun, parity_error;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] sb[$];

    serial_receiver #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
        .dout(dout), .valid(valid), .empty(empty), .full(full),
        .data_count(data_count), .framing_error(framing_error),
        .overrun(overrun), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (framing_error) ferr_cnt++;
            if (overrun)       ovr_cnt++;
            if (parity_error)  perr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int abort_bit);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                repeat (BITC/2) @(negedge clk);
                return;
            end
            repeat (BITC) @(negedge clk);
        end
`ifdef SERIAL_RECEIVER_PARITY_EN
        rx = par;
        repeat (BITC) @(negedge clk);
`endif
        rx = stop;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        if (sb.size() < DEPTH) sb.push_back(d);
        send_frame(d, ^d, 1'b1, -1);
        repeat (5) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        chk({tag, "_valid"}, valid, 1'b1);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk({tag, "_head"}, dout, e);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk({tag, "_count"}, data_count, sb.size());
        if (sb.size() > 0) chk({tag, "_next"}, dout, sb[0]);
    endtask

    initial begin
        int f0, o0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", data_count, 3'd0);

        send_good(8'h55);
        send_good(8'hA3);
        chk("two_count", data_count, 3'd2);
        chk("two_head", dout, 8'h55);
        pop_check("pop55");
        pop_check("popA3");
        chk("drained_valid", valid, 1'b0);

        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        chk("glitch_count", data_count, 3'd0);
        chk("glitch_ferr", ferr_cnt, 0);
        send_good(8'h3C);
        pop_check("pop3C");

        send_frame(8'hF0, ^8'hF0, 1'b0, -1);
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("frame_err_pulse", ferr_cnt, 1);
        chk("frame_err_count", data_count, 3'd0);
        send_good(8'h12);
        pop_check("pop12");

        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_good(8'(i));
        chk("four_full", full, 1'b1);
        chk("four_count", data_count, 3'd4);
        send_good(8'h05);
        chk("overrun_pulse", ovr_cnt - o0, 1);
        chk("overrun_count", data_count, 3'd4);
        for (int i = 0; i < 4; i++) pop_check("pop_fill");
        chk("fill_empty", empty, 1'b1);

        send_good(8'h5A);
        send_frame(8'h99, ^8'h99, 1'b1, 4);
        rst = 1'b1;
        rx = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_count", data_count, 3'd0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_ferr", framing_error, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        chk("post_rst_count", data_count, 3'd0);
        send_good(8'h66);
        chk("post_rst_one", data_count, 3'd1);
        pop_check("pop66");

        f0 = ferr_cnt;
`ifdef SERIAL_RECEIVER_PARITY_EN
        send_good(8'h07);
        chk("par_ok_count", data_count, 3'd1);
        pop_check("pop07");
        send_frame(8'h07, 1'b0, 1'b1, -1);
        repeat (5) @(negedge clk);
        chk("par_bad_pulse", perr_cnt, 1);
        chk("par_bad_count", data_count, 3'd0);
        chk("par_bad_ferr", ferr_cnt - f0, 0);
`else
        send_good(8'h07);
        pop_check("pop07");
        chk("no_parity_pulse", perr_cnt, 0);
        chk("no_extra_ferr", ferr_cnt - f0, 0);
`endif
        chk("total_overrun", ovr_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
